// File: rtl/spi_fnd_master.sv
// SPI master (CPOL=0, CPHA=0, MSB first) that ships a 0..9999 display value
// to the FND slave board as two bytes, hi = value/100 then lo = value%100,
// inside a single SS_N frame.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | SS_N high, waiting for start; a second cycle loads the pins
// S_LEAD    | SS_N low, SCLK low, first bit set up on MOSI
// S_SCLK_HI | SCLK high, slave samples MOSI on the rising edge
// S_SCLK_LO | SCLK low, next bit placed on MOSI on entry
// S_TRAIL   | SCLK low hold after the last bit, then release SS_N

module spi_fnd_master #(
    parameter int CLK_DIV = 50
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [13:0] value,
    input  logic        i_MISO,
    output logic        o_SCLK,
    output logic        o_MOSI,
    output logic        o_SS_N,
    output logic        busy,
    output logic        done
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LEAD    = 3'd1;
    localparam logic [2:0] S_SCLK_HI = 3'd2;
    localparam logic [2:0] S_SCLK_LO = 3'd3;
    localparam logic [2:0] S_TRAIL   = 3'd4;

    logic [2:0]    state;
    logic [DW-1:0] div_cnt;
    logic [3:0]    bit_cnt;
    logic [15:0]   shreg;
    logic          accepted;
    logic          div_last;

    logic [13:0]   v_sat;
    logic [7:0]    hi_byte;
    logic [7:0]    lo_byte;

    // The link is one-way; MISO is kept on the port only for board compatibility.
    logic          miso_unused;
    assign miso_unused = i_MISO;

    // Saturate to the displayable range and split into the two decimal bytes.
    always_comb begin
        v_sat   = (value > 14'd9999) ? 14'd9999 : value;
        hi_byte = 8'(v_sat / 14'd100);
        lo_byte = 8'(v_sat % 14'd100);
    end

    assign div_last = (div_cnt == DW'(CLK_DIV - 1));

    // Frame sequencer: every non-idle state lasts CLK_DIV clocks.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            accepted <= 1'b0;
            o_SCLK   <= 1'b0;
            o_MOSI   <= 1'b0;
            o_SS_N   <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    div_cnt <= '0;
                    bit_cnt <= '0;
                    // Accept latches the word; the pins follow one clock later.
                    if (accepted) begin
                        accepted <= 1'b0;
                        o_SS_N   <= 1'b0;
                        o_MOSI   <= shreg[15];
                        busy     <= 1'b1;
                        state    <= S_LEAD;
                    end else if (start) begin
                        shreg    <= {hi_byte, lo_byte};
                        accepted <= 1'b1;
                    end
                end
                S_LEAD: begin
                    if (div_last) begin
                        div_cnt <= '0;
                        o_SCLK  <= 1'b1;
                        state   <= S_SCLK_HI;
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end
                S_SCLK_HI: begin
                    if (div_last) begin
                        div_cnt <= '0;
                        o_SCLK  <= 1'b0;
                        if (bit_cnt == 4'd15) begin
                            state <= S_TRAIL;
                        end else begin
                            shreg   <= {shreg[14:0], 1'b0};
                            o_MOSI  <= shreg[14];
                            bit_cnt <= bit_cnt + 4'd1;
                            state   <= S_SCLK_LO;
                        end
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end
                S_SCLK_LO: begin
                    if (div_last) begin
                        div_cnt <= '0;
                        o_SCLK  <= 1'b1;
                        state   <= S_SCLK_HI;
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end
                S_TRAIL: begin
                    if (div_last) begin
                        div_cnt <= '0;
                        o_SS_N  <= 1'b1;
                        o_MOSI  <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= S_IDLE;
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_fnd_master.sv
// Bench for spi_fnd_master: two instances (CLK_DIV=4 and CLK_DIV=50) checked
// every cycle against a waveform model computed from the frame offset since
// accept, plus a CPOL0/CPHA0 receiver that rebuilds the displayed value.

module tb_spi_fnd_master;

    logic        clk;
    logic        reset;
    logic        start0;
    logic        start1;
    logic [13:0] value;
    logic        miso;
    logic        sclk  [2];
    logic        mosi  [2];
    logic        ss_n  [2];
    logic        busy  [2];
    logic        done  [2];

    int n_cmp;
    int n_bad;

    spi_fnd_master #(.CLK_DIV(4)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .value(value), .i_MISO(miso),
        .o_SCLK(sclk[0]), .o_MOSI(mosi[0]), .o_SS_N(ss_n[0]),
        .busy(busy[0]), .done(done[0])
    );

    spi_fnd_master #(.CLK_DIV(50)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .value(value), .i_MISO(miso),
        .o_SCLK(sclk[1]), .o_MOSI(mosi[1]), .o_SS_N(ss_n[1]),
        .busy(busy[1]), .done(done[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected encoded word: saturate, then decimal hundreds / remainder.
    function automatic logic [15:0] enc(input int val);
        int v;
        v = (val > 9999) ? 9999 : val;
        return {8'(v / 100), 8'(v % 100)};
    endfunction

    // Expected {ss_n, sclk, mosi, busy, done} k clocks after the accept edge.
    function automatic logic [4:0] exp_frame(input int k, input logic [15:0] w, input int d);
        int   t;
        int   m;
        int   idx;
        logic sc;
        t = 1 + 33 * d;
        if (k < 1 || k > t) return 5'b10000;
        if (k == t) return 5'b10001;
        m = k - 1 - d;
        if (m < 0) idx = 0;
        else begin
            idx = (m / d + 1) / 2;
            if (idx > 15) idx = 15;
        end
        sc = (m >= 0) && (m < 31 * d) && ((m / d) % 2 == 0);
        return {1'b0, sc, w[15 - idx], 1'b1, 1'b0};
    endfunction

    // Model state per instance.
    int          cyc;
    bit          active  [2];
    int          t0      [2];
    logic [15:0] word    [2];
    int          vsat    [2];
    bit          chk_en;

    // Receiver and done bookkeeping per instance.
    logic [15:0] rx_sh   [2];
    int          rx_n    [2];
    logic        prev_sc [2];
    logic [15:0] rx_last [2];
    int          done_cnt[2];
    int          lat_last[2];

    // Model update on the clock edge from the inputs the bench is driving.
    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int i = 0; i < 2; i++) begin
            int   d;
            logic st;
            d  = (i == 0) ? 4 : 50;
            st = (i == 0) ? start0 : start1;
            if (!reset) active[i] = 1'b0;
            else if (active[i] && cyc > t0[i] + 1 + 33 * d) active[i] = 1'b0;
            if (reset && !active[i] && st) begin
                active[i] = 1'b1;
                t0[i]     = cyc;
                word[i]   = enc(int'(value));
                vsat[i]   = (value > 14'd9999) ? 9999 : int'(value);
            end
        end
    end

    // Per-cycle output compare and SPI receiver, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                int         d;
                logic [4:0] e;
                d = (i == 0) ? 4 : 50;
                e = active[i] ? exp_frame(cyc - t0[i], word[i], d) : 5'b10000;
                chk(i == 0 ? "pins_div4" : "pins_div50",
                    {27'd0, ss_n[i], sclk[i], mosi[i], busy[i], done[i]}, {27'd0, e});
                if (done[i] === 1'b1) begin
                    chk("rx_bits", rx_n[i], 16);
                    chk("rx_word", rx_sh[i], word[i]);
                    chk("rebuild", int'(rx_sh[i][15:8]) * 100 + int'(rx_sh[i][7:0]), vsat[i]);
                    rx_last[i]  = rx_sh[i];
                    lat_last[i] = cyc - t0[i];
                    done_cnt[i] = done_cnt[i] + 1;
                end
                if (ss_n[i] !== 1'b0) begin
                    rx_sh[i] = '0;
                    rx_n[i]  = 0;
                end else if (prev_sc[i] === 1'b0 && sclk[i] === 1'b1) begin
                    rx_sh[i] = {rx_sh[i][14:0], mosi[i]};
                    rx_n[i]  = rx_n[i] + 1;
                end
                prev_sc[i] = sclk[i];
            end
        end
    end

    task automatic wait_done(input int i, input int budget);
        int c0;
        c0 = done_cnt[i];
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            #1;
            if (done_cnt[i] != c0) return;
        end
        n_bad++;
        $display("FAIL done_timeout inst %0d: no done within %0d cycles", i, budget);
    endtask

    task automatic send(input int i, input int val);
        @(negedge clk);
        #2;
        value = 14'(val);
        if (i == 0) start0 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        #2;
        start0 = 1'b0;
        start1 = 1'b0;
        wait_done(i, 4000);
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) @(negedge clk);
    endtask

    initial begin
        logic [15:0] first_rx;
        n_cmp = 0; n_bad = 0; cyc = 0; chk_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            active[i] = 0; t0[i] = 0; word[i] = '0; vsat[i] = 0;
            rx_sh[i] = '0; rx_n[i] = 0; prev_sc[i] = 1'b0; rx_last[i] = '0;
            done_cnt[i] = 0; lat_last[i] = 0;
        end
        reset = 1'b0; start0 = 1'b0; start1 = 1'b0; value = '0; miso = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        idle(2);
        #2 reset = 1'b1;
        idle(2);

        // Model pins against hand-computed encodings.
        chk("enc_1234", enc(1234), 16'h0C22);
        chk("enc_12000", enc(12000), 16'h6363);
        chk("enc_4321", enc(4321), 16'h2B15);

        // Basic frame and its exact length.
        send(0, 1234);
        chk("rx_1234", rx_last[0], 16'h0C22);
        chk("lat_div4", lat_last[0], 133);
        send(0, 9999);
        chk("rx_9999", rx_last[0], 16'h6363);
        send(0, 0);
        chk("rx_0", rx_last[0], 16'h0000);
        send(0, 12000);
        chk("rx_12000", rx_last[0], 16'h6363);

        // start held through the frame with value changed mid-frame.
        @(negedge clk);
        #2 value = 14'd777; start0 = 1'b1;
        idle(20);
        #2 value = 14'd5;
        wait_done(0, 400);
        first_rx = rx_last[0];
        chk("held_rx_777", first_rx, 16'h074D);
        idle(2);
        chk("b2b_ss_low", ss_n[0], 1'b0);
        #2 start0 = 1'b0;
        wait_done(0, 400);
        chk("b2b_rx_5", rx_last[0], 16'h0005);

        // Reset in the middle of bit 7, then a clean frame.
        send(0, 4321);
        @(negedge clk);
        #2 value = 14'd4321; start0 = 1'b1;
        @(negedge clk);
        #2 start0 = 1'b0;
        idle(59);
        #2 reset = 1'b0;
        @(negedge clk);
        chk("rst_ss_n", ss_n[0], 1'b1);
        chk("rst_busy", busy[0], 1'b0);
        chk("rst_sclk", sclk[0], 1'b0);
        #2 reset = 1'b1;
        idle(3);
        send(0, 4321);
        chk("after_rst_rx", rx_last[0], 16'h2B15);
        chk("after_rst_lat", lat_last[0], 133);

        // Randomised frames, with stray start pulses while busy.
        for (int r = 0; r < 12; r++) begin
            int val;
            val = int'($urandom_range(0, 16383));
            idle(int'($urandom_range(0, 5)));
            @(negedge clk);
            #2 value = 14'(val); start0 = 1'b1;
            @(negedge clk);
            #2 start0 = 1'b0;
            idle(int'($urandom_range(2, 100)));
            #2 start0 = 1'b1; value = 14'($urandom_range(0, 16383));
            @(negedge clk);
            #2 start0 = 1'b0;
            wait_done(0, 400);
            chk("rand_rx", rx_last[0], enc(val));
        end

        // Slow divider: full-speed timing at CLK_DIV=50.
        send(1, 4321);
        chk("rx_div50", rx_last[1], 16'h2B15);
        chk("lat_div50", lat_last[1], 1651);

        idle(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
